// File: rtl/regbench_param.sv
// regbench_param: 2**ADDR_W x DATA_W register file, 3 read ports, bulk clear.
// Define REGBENCH_BYPASS_EN to forward same-cycle writes onto data1/data2.
module regbench_param #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] readAddy1,
    input  logic [ADDR_W-1:0] readAddy2,
    input  logic [ADDR_W-1:0] writeAddy,
    input  logic [DATA_W-1:0] writeData,
    input  logic              cu_writeReg,
    input  logic              clearReq,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    output logic [DATA_W-1:0] data3,
    output logic              busy,
    output logic              clearDone
);

    localparam int NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ONE_IDX  = ADDR_W'(1);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              w_wr_en;
    logic              w_clr_en;
    logic [DATA_W-1:0] r_mem [NREG];
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    logic [DATA_W-1:0] w_rd3;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
        w_wr_en     = 1'b0;
        w_clr_en    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_wr_en = cu_writeReg && (writeAddy != '0);
                if (clearReq) begin
                    w_state_nxt = S_CLEAR;
                    w_idx_nxt   = ONE_IDX;
                end
            end
            S_CLEAR: begin
                w_clr_en = 1'b1;
                // Hold the index on the final entry so it never wraps to 0.
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + ONE_IDX;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[writeAddy] <= writeData;
        end else if (w_clr_en) begin
            r_mem[r_idx] <= '0;
        end
    end

    always_comb begin
        w_rd1 = (readAddy1 == '0) ? '0 : r_mem[readAddy1];
        w_rd2 = (readAddy2 == '0) ? '0 : r_mem[readAddy2];
        w_rd3 = (writeAddy == '0) ? '0 : r_mem[writeAddy];
`ifdef REGBENCH_BYPASS_EN
        // w_wr_en already excludes address 0 and the CLEAR state.
        if (w_wr_en && (writeAddy == readAddy1)) begin
            w_rd1 = writeData;
        end
        if (w_wr_en && (writeAddy == readAddy2)) begin
            w_rd2 = writeData;
        end
`endif
    end

    assign data1     = w_rd1;
    assign data2     = w_rd2;
    assign data3     = w_rd3;
    assign busy      = (r_state == S_CLEAR);
    assign clearDone = r_done;

endmodule
